// File: rtl/t03_dpu_frame_latch.sv
// t03_dpu_frame_latch: CPU-facing shadow register bank for the DPU.
// CPU writes land in a shadow copy. A commit request copies the shadow to
// the active outputs at the next vertical-blank start, or at once for an
// immediate commit, so a frame never mixes old and new display values.
module t03_dpu_frame_latch #(
  parameter logic [10:0] VBLANK_LINE = 11'd480,
  parameter logic [10:0] X_MAX       = 11'd799,
  parameter logic [10:0] Y_MAX       = 11'd500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  input  logic [10:0] Hcnt,
  input  logic [10:0] Vcnt,
  output logic [2:0]  gameState,
  output logic [1:0]  p1State,
  output logic [1:0]  p2State,
  output logic [3:0]  p1health,
  output logic [3:0]  p2health,
  output logic        p1Left,
  output logic        p2Left,
  output logic [10:0] x1,
  output logic [10:0] y1,
  output logic [10:0] x2,
  output logic [10:0] y2,
  output logic        pending,
  output logic        commit_pulse,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    COMMIT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic        vb_evt;
  logic        wr_acc;
  logic [10:0] x_clamped;
  logic [10:0] y_clamped;

  logic [2:0]  sh_gameState;
  logic [1:0]  sh_p1State;
  logic [1:0]  sh_p2State;
  logic [3:0]  sh_p1health;
  logic [3:0]  sh_p2health;
  logic        sh_p1Left;
  logic        sh_p2Left;
  logic [10:0] sh_x1;
  logic [10:0] sh_y1;
  logic [10:0] sh_x2;
  logic [10:0] sh_y2;

  // Vblank start marker and clamped coordinates from the incoming word
  always_comb begin
    vb_evt    = (Vcnt == VBLANK_LINE) && (Hcnt == '0);
    wr_acc    = wr_en && wr_ready;
    x_clamped = (wr_data[10:0]  > X_MAX) ? X_MAX : wr_data[10:0];
    y_clamped = (wr_data[26:16] > Y_MAX) ? Y_MAX : wr_data[26:16];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs; a vblank coinciding with the
  // request in IDLE is deliberately ignored, so the commit waits a frame
  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    pending   = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        if (wr_en && (wr_addr == 2'd3)) begin
          if (wr_data[1]) begin
            state_nxt = COMMIT;
          end else if (wr_data[0]) begin
            state_nxt = PENDING;
          end
        end
      end
      PENDING: begin
        pending = 1'b1;
        if (vb_evt) begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        pending   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Shadow bank: accepts CPU words only while IDLE
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_gameState <= '0;
      sh_p1State   <= '0;
      sh_p2State   <= '0;
      sh_p1Left    <= 1'b0;
      sh_p2Left    <= 1'b0;
      sh_p1health  <= '0;
      sh_p2health  <= '0;
      sh_x1        <= '0;
      sh_y1        <= '0;
      sh_x2        <= '0;
      sh_y2        <= '0;
    end else if (wr_acc) begin
      case (wr_addr)
        2'd0: begin
          sh_gameState <= wr_data[2:0];
          sh_p1State   <= wr_data[4:3];
          sh_p2State   <= wr_data[6:5];
          sh_p1Left    <= wr_data[7];
          sh_p2Left    <= wr_data[8];
          sh_p1health  <= wr_data[12:9];
          sh_p2health  <= wr_data[16:13];
        end
        2'd1: begin
          sh_x1 <= x_clamped;
          sh_y1 <= y_clamped;
        end
        2'd2: begin
          sh_x2 <= x_clamped;
          sh_y2 <= y_clamped;
        end
        default: begin
        end
      endcase
    end
  end

  // Active bank: loaded from the shadow on the edge that leaves COMMIT
  always_ff @(posedge clk) begin
    if (!rst) begin
      gameState <= '0;
      p1State   <= '0;
      p2State   <= '0;
      p1Left    <= 1'b0;
      p2Left    <= 1'b0;
      p1health  <= '0;
      p2health  <= '0;
      x1        <= '0;
      y1        <= '0;
      x2        <= '0;
      y2        <= '0;
    end else if (state == COMMIT) begin
      gameState <= sh_gameState;
      p1State   <= sh_p1State;
      p2State   <= sh_p2State;
      p1Left    <= sh_p1Left;
      p2Left    <= sh_p2Left;
      p1health  <= sh_p1health;
      p2health  <= sh_p2health;
      x1        <= sh_x1;
      y1        <= sh_y1;
      x2        <= sh_x2;
      y2        <= sh_y2;
    end
  end

  // Registered commit pulse (high while in COMMIT) and commit counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      commit_pulse <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      commit_pulse <= (state_nxt == COMMIT);
      if (state == COMMIT) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule
